// File: rtl/trace_capture_if.sv
// Monitored-bus, control and readout signals of the trace_capture debug block.
// The slave modport is the capture block's view; the master modport is the host's view.
interface trace_capture_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned ADDR_W   = 4
);
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [SEL_W-1:0]          sel;
  logic [1:0]                mode;
  logic [WIDTH-1:0]          match_val;
  logic                      arm;
  logic                      stop;
  logic [WIDTH-1:0]          live_out;
  logic [ADDR_W-1:0]         rd_addr;
  logic [WIDTH-1:0]          rd_data;
  logic [ADDR_W:0]           count;
  logic                      busy;
  logic                      done;
  logic                      wrapped;

  modport master (
    output ch_data, sel, mode, match_val, arm, stop, rd_addr,
    input  live_out, rd_data, count, busy, done, wrapped
  );

  modport slave (
    input  ch_data, sel, mode, match_val, arm, stop, rd_addr,
    output live_out, rd_data, count, busy, done, wrapped
  );
endinterface

// File: rtl/trace_capture.sv
// Selectable debug channel with a registered live view and a DEPTH-entry trace RAM
// recorded under arm/stop/trigger control, read back oldest-first.
module trace_capture #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          WRAP     = 1'b0
) (
  input logic            clk,
  input logic            reset,
  trace_capture_if.slave bus
);
  localparam int unsigned     DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t             state;
  logic [SEL_W-1:0]   lat_sel;
  logic [1:0]         lat_mode;
  logic [WIDTH-1:0]   lat_match;
  logic [WIDTH-1:0]   prev_val;
  logic               first;
  logic [ADDR_W-1:0]  wptr;
  logic [ADDR_W:0]    count_q;
  logic               wrapped_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   live_q;
  logic [WIDTH-1:0]   rd_q;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic [WIDTH-1:0]   cur_val;
  logic               arm_go;
  logic               wr_en;
  logic [ADDR_W-1:0]  rd_phys;

  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0] s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      if (32'(s) == k) r = d[k*WIDTH +: WIDTH];
    return r;
  endfunction

  // arm or stop in a cycle always pre-empts that cycle's write.
  always_comb begin
    cur_val = pick(bus.ch_data, lat_sel);
    arm_go  = bus.arm & ~bus.stop;
    wr_en   = 1'b0;
    if (!bus.arm && !bus.stop) begin
      case (state)
        ARMED:   wr_en = (cur_val == lat_match);
        CAPTURE: wr_en = (lat_mode != 2'd1) || first || (cur_val != prev_val);
        default: wr_en = 1'b0;
      endcase
    end
    rd_phys = wrapped_q ? wptr + bus.rd_addr : bus.rd_addr;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= cur_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat_sel   <= '0;
      lat_mode  <= '0;
      lat_match <= '0;
      prev_val  <= '0;
      first     <= 1'b0;
      wptr      <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      live_q    <= '0;
      rd_q      <= '0;
    end else begin
      live_q <= pick(bus.ch_data, bus.sel);
      rd_q   <= ({1'b0, bus.rd_addr} >= count_q) ? '0 : mem[rd_phys];

      // An accepted arm starts afresh from any state, including mid-capture.
      if (arm_go) begin
        lat_sel   <= bus.sel;
        lat_mode  <= bus.mode;
        lat_match <= bus.match_val;
        first     <= 1'b1;
        wptr      <= '0;
        count_q   <= '0;
        wrapped_q <= 1'b0;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
        state     <= (bus.mode == 2'd2) ? ARMED : CAPTURE;
      end else if (bus.stop && busy_q) begin
        state  <= DONE;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        if (state == CAPTURE) begin
          prev_val <= cur_val;
          first    <= 1'b0;
        end
        if (wr_en) begin
          wptr <= wptr + 1'b1;
          if (count_q == FULL) wrapped_q <= 1'b1;
          else                 count_q   <= count_q + 1'b1;
          if (!WRAP && (count_q + 1'b1 == FULL)) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
      end
    end
  end

  assign bus.live_out = live_q;
  assign bus.rd_data  = rd_q;
  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wrapped  = wrapped_q;
endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: a stop-when-full and a circular instance share all stimulus;
// expected traces come from post-processing the driven channel stream.
module tb_trace_capture;
  localparam int W = 32, CH = 4, SW = 4, AW = 4, DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CH*W-1:0] ch_data;
  logic [SW-1:0]   sel;
  logic [1:0]      mode;
  logic [W-1:0]    match_val;
  logic            arm, stop;
  logic [AW-1:0]   rd_addr;

  trace_capture_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .ADDR_W(AW)) bus0 ();
  trace_capture_if #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .ADDR_W(AW)) bus1 ();

  assign bus0.ch_data = ch_data;   assign bus1.ch_data = ch_data;
  assign bus0.sel = sel;           assign bus1.sel = sel;
  assign bus0.mode = mode;         assign bus1.mode = mode;
  assign bus0.match_val = match_val; assign bus1.match_val = match_val;
  assign bus0.arm = arm;           assign bus1.arm = arm;
  assign bus0.stop = stop;         assign bus1.stop = stop;
  assign bus0.rd_addr = rd_addr;   assign bus1.rd_addr = rd_addr;

  trace_capture #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .ADDR_W(AW), .WRAP(1'b0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  trace_capture #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .ADDR_W(AW), .WRAP(1'b1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int errors = 0;
  logic [1:0]   hist[$];
  logic [W-1:0] exp0[$];
  logic [W-1:0] exp1[$];
  bit           expw1;
  logic [W-1:0] got0[DEPTH];
  logic [W-1:0] got1[DEPTH];

  task automatic set_ch(input int s, input logic [W-1:0] v);
    for (int k = 0; k < CH; k++) ch_data[k*W +: W] = $urandom;
    if (s < CH) ch_data[s*W +: W] = v;
  endtask

  // Arm, feed one value per cycle on channel s (other inputs scrambled), then pulse stop.
  task automatic run_capture(input int md, input int s, input logic [W-1:0] mv,
                             input logic [W-1:0] vals[$]);
    hist = {};
    @(negedge clk);
    arm = 1'b1; stop = 1'b0; sel = SW'(s); mode = 2'(md); match_val = mv;
    set_ch(s, $urandom);
    foreach (vals[i]) begin
      @(negedge clk);
      hist.push_back({bus0.busy, bus0.done});
      arm = 1'b0; sel = SW'($urandom); mode = 2'($urandom); match_val = $urandom;
      set_ch(s, vals[i]);
    end
    @(negedge clk);
    hist.push_back({bus0.busy, bus0.done});
    stop = 1'b1;
    set_ch(s, $urandom);
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic model_expect(input int md, input logic [W-1:0] mv, input logic [W-1:0] vals[$]);
    logic [W-1:0] stream[$];
    bit started;
    started = (md != 2);
    stream = {};
    foreach (vals[i]) begin
      if (!started && vals[i] == mv) started = 1'b1;
      if (started && !(md == 1 && i > 0 && vals[i] == vals[i-1])) stream.push_back(vals[i]);
    end
    exp0 = {};
    exp1 = {};
    foreach (stream[j]) begin
      if (j < DEPTH) exp0.push_back(stream[j]);
      if (j >= int'(stream.size()) - DEPTH) exp1.push_back(stream[j]);
    end
    expw1 = stream.size() > DEPTH;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk); rd_addr = AW'(a);
      @(negedge clk); got0[a] = bus0.rd_data; got1[a] = bus1.rd_data;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; stop = 1'b0; sel = '0; mode = '0; match_val = '0;
    rd_addr = '0; ch_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus0.live_out !== '0) begin errors++; $display("FAIL reset_live: got %0h expected 0", bus0.live_out); end
    checks++; if (bus0.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", bus0.rd_data); end
    checks++; if (bus0.count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus0.count); end
    checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
    checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus0.done); end
    checks++; if (bus0.wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped: got %b expected 0", bus0.wrapped); end
    checks++;
    if ({bus1.live_out, bus1.rd_data, bus1.count, bus1.busy, bus1.done, bus1.wrapped} !== '0) begin
      errors++; $display("FAIL reset_dut1: got %0h expected 0",
        {bus1.live_out, bus1.rd_data, bus1.count, bus1.busy, bus1.done, bus1.wrapped});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_live();
    logic [W-1:0] exp;
    int s;
    @(negedge clk); sel = SW'(1); set_ch(1, 32'hA5A5_0001);
    @(negedge clk);
    checks++; if (bus0.live_out !== 32'hA5A5_0001) begin errors++; $display("FAIL live_sel1: got %0h expected a5a50001", bus0.live_out); end
    sel = SW'(7);
    @(negedge clk);
    checks++; if (bus0.live_out !== '0) begin errors++; $display("FAIL live_sel7: got %0h expected 0", bus0.live_out); end
    repeat (8) begin
      s = $urandom_range(0, 15);
      sel = SW'(s); set_ch(0, $urandom);
      exp = (s < CH) ? ch_data[s*W +: W] : '0;
      @(negedge clk);
      checks++; if (bus1.live_out !== exp) begin errors++; $display("FAIL live_rand sel=%0d: got %0h expected %0h", s, bus1.live_out, exp); end
    end
  endtask

  task automatic test_mode0();
    logic [W-1:0] vals[$];
    vals = {};
    for (int i = 0; i < 20; i++) vals.push_back(W'(i));
    run_capture(0, 0, '0, vals);
    read_all();
    checks++; if (bus0.count !== 5'd16) begin errors++; $display("FAIL m0_count: got %0d expected 16", bus0.count); end
    checks++; if ({bus0.busy, bus0.done} !== 2'b01) begin errors++; $display("FAIL m0_busy_done: got %b expected 01", {bus0.busy, bus0.done}); end
    checks++; if (hist[15] !== 2'b10) begin errors++; $display("FAIL m0_after15: got %b expected 10", hist[15]); end
    checks++; if (hist[16] !== 2'b01) begin errors++; $display("FAIL m0_after16: got %b expected 01", hist[16]); end
    for (int a = 0; a < DEPTH; a++) begin
      checks++; if (got0[a] !== W'(a)) begin errors++; $display("FAIL m0_rd[%0d]: got %0h expected %0h", a, got0[a], a); end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] vals[$];
    vals = {};
    for (int i = 0; i < 20; i++) vals.push_back(W'(i));
    run_capture(0, 0, '0, vals);
    read_all();
    checks++; if (bus1.wrapped !== 1'b1) begin errors++; $display("FAIL wrap_flag: got %b expected 1", bus1.wrapped); end
    checks++; if (bus1.count !== 5'd16) begin errors++; $display("FAIL wrap_count: got %0d expected 16", bus1.count); end
    checks++; if (got1[0] !== 32'd4) begin errors++; $display("FAIL wrap_rd0: got %0h expected 4", got1[0]); end
    checks++; if (got1[15] !== 32'd19) begin errors++; $display("FAIL wrap_rd15: got %0h expected 13", got1[15]); end
    checks++; if (bus0.wrapped !== 1'b0) begin errors++; $display("FAIL nowrap_flag: got %b expected 0", bus0.wrapped); end
  endtask

  task automatic test_mode1();
    logic [W-1:0] vals[$];
    logic [W-1:0] want[4];
    vals = {32'd5, 32'd5, 32'd5, 32'd9, 32'd9, 32'd4};
    want = '{32'd5, 32'd9, 32'd4, 32'd0};
    run_capture(1, 2, '0, vals);
    read_all();
    checks++; if (bus0.count !== 5'd3) begin errors++; $display("FAIL m1_count: got %0d expected 3", bus0.count); end
    checks++; if (bus1.count !== 5'd3) begin errors++; $display("FAIL m1_count_wrapinst: got %0d expected 3", bus1.count); end
    for (int a = 0; a < 4; a++) begin
      checks++; if (got0[a] !== want[a]) begin errors++; $display("FAIL m1_rd[%0d]: got %0h expected %0h", a, got0[a], want[a]); end
    end
  endtask

  task automatic test_mode2();
    logic [W-1:0] vals[$];
    vals = {};
    for (int i = 0; i < 64; i++) vals.push_back(W'(i));
    run_capture(2, 0, 32'h20, vals);
    read_all();
    checks++; if (hist[32] !== 2'b10) begin errors++; $display("FAIL m2_armed: got %b expected 10", hist[32]); end
    checks++; if (bus0.done !== 1'b1) begin errors++; $display("FAIL m2_done: got %b expected 1", bus0.done); end
    checks++; if (bus0.count !== 5'd16) begin errors++; $display("FAIL m2_count: got %0d expected 16", bus0.count); end
    checks++; if (got0[0] !== 32'h20) begin errors++; $display("FAIL m2_rd0: got %0h expected 20", got0[0]); end
    checks++; if (got0[15] !== 32'h2F) begin errors++; $display("FAIL m2_rd15: got %0h expected 2f", got0[15]); end
    checks++; if (got1[0] !== 32'h30) begin errors++; $display("FAIL m2_wrap_rd0: got %0h expected 30", got1[0]); end
    checks++; if (got1[15] !== 32'h3F) begin errors++; $display("FAIL m2_wrap_rd15: got %0h expected 3f", got1[15]); end
  endtask

  task automatic test_arm_stop();
    logic [W-1:0] vals[$];
    @(negedge clk); arm = 1'b1; sel = '0; mode = '0; set_ch(0, 32'd100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); arm = 1'b0; set_ch(0, W'(100 + i));
    end
    @(negedge clk); arm = 1'b1; stop = 1'b1; set_ch(0, 32'd999);
    @(negedge clk); arm = 1'b0; stop = 1'b0;
    checks++; if (bus0.count !== 5'd5) begin errors++; $display("FAIL armstop_count: got %0d expected 5", bus0.count); end
    checks++; if ({bus0.busy, bus0.done} !== 2'b01) begin errors++; $display("FAIL armstop_state: got %b expected 01", {bus0.busy, bus0.done}); end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    @(negedge clk);
    checks++; if ({bus0.done, bus0.count} !== {1'b1, 5'd5}) begin errors++; $display("FAIL stop_in_done: got %0h expected 25", {bus0.done, bus0.count}); end

    // Restart while busy: only the second capture's data survives.
    @(negedge clk); arm = 1'b1; sel = '0; mode = '0; set_ch(0, $urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); arm = 1'b0; set_ch(0, $urandom);
    end
    vals = {};
    for (int i = 0; i < 6; i++) vals.push_back($urandom);
    run_capture(0, 3, '0, vals);
    read_all();
    checks++; if (bus0.count !== 5'd6) begin errors++; $display("FAIL restart_count: got %0d expected 6", bus0.count); end
    for (int a = 0; a < 7; a++) begin
      checks++;
      if (got0[a] !== ((a < 6) ? vals[a] : '0)) begin
        errors++; $display("FAIL restart_rd[%0d]: got %0h expected %0h", a, got0[a], (a < 6) ? vals[a] : '0);
      end
    end

    @(negedge clk); rd_addr = '0; arm = 1'b1; sel = SW'(1); mode = '0; set_ch(1, $urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); arm = 1'b0; set_ch(1, $urandom);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus0.live_out, bus0.rd_data, bus0.count, bus0.busy, bus0.done, bus0.wrapped} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %0h expected 0",
        {bus0.live_out, bus0.rd_data, bus0.count, bus0.busy, bus0.done, bus0.wrapped});
    end
    @(negedge clk); reset = 1'b0;
    vals = {};
    for (int i = 0; i < 4; i++) vals.push_back($urandom);
    run_capture(0, 1, '0, vals);
    read_all();
    checks++; if (bus0.count !== 5'd4) begin errors++; $display("FAIL postreset_count: got %0d expected 4", bus0.count); end
    checks++; if (got0[0] !== vals[0]) begin errors++; $display("FAIL postreset_rd0: got %0h expected %0h", got0[0], vals[0]); end
    checks++; if (got0[3] !== vals[3]) begin errors++; $display("FAIL postreset_rd3: got %0h expected %0h", got0[3], vals[3]); end
  endtask

  task automatic test_random();
    logic [W-1:0] vals[$];
    logic [W-1:0] mv, e;
    int md, s, n;
    for (int it = 0; it < 12; it++) begin
      md = $urandom_range(0, 3);
      s  = $urandom_range(0, 4);
      n  = $urandom_range(1, 24);
      mv = W'($urandom_range(0, 3));
      vals = {};
      for (int i = 0; i < n; i++) vals.push_back((s < CH) ? W'($urandom_range(0, 3)) : '0);
      run_capture(md, s, mv, vals);
      model_expect(md, mv, vals);
      read_all();
      checks++; if (bus0.count !== 5'(exp0.size())) begin errors++; $display("FAIL rnd%0d_count0: got %0d expected %0d", it, bus0.count, exp0.size()); end
      checks++; if (bus1.count !== 5'(exp1.size())) begin errors++; $display("FAIL rnd%0d_count1: got %0d expected %0d", it, bus1.count, exp1.size()); end
      checks++; if (bus1.wrapped !== expw1) begin errors++; $display("FAIL rnd%0d_wrapped1: got %b expected %b", it, bus1.wrapped, expw1); end
      checks++;
      if ({bus0.busy, bus0.done, bus1.busy, bus1.done} !== 4'b0101) begin
        errors++; $display("FAIL rnd%0d_state: got %b expected 0101", it, {bus0.busy, bus0.done, bus1.busy, bus1.done});
      end
      for (int a = 0; a < DEPTH; a++) begin
        e = (a < exp0.size()) ? exp0[a] : '0;
        checks++; if (got0[a] !== e) begin errors++; $display("FAIL rnd%0d_rd0[%0d]: got %0h expected %0h", it, a, got0[a], e); end
        e = (a < exp1.size()) ? exp1[a] : '0;
        checks++; if (got1[a] !== e) begin errors++; $display("FAIL rnd%0d_rd1[%0d]: got %0h expected %0h", it, a, got1[a], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_live();
    test_mode0();
    test_wrap();
    test_mode1();
    test_mode2();
    test_arm_stop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Parametrised successor to the fixed 4-bit test_sel / 32-bit test_out debug path around computer.
- Selects one of CHANNELS monitored buses, presents it registered on live_out, and records it into a DEPTH-entry trace RAM under start/stop/trigger control.
- Used by the simulation benches and the FPGA top for post-run readout.

Parameters:
- WIDTH, 32, width of each monitored channel and of all data outputs.
- CHANNELS, 4, number of monitored channels (1..2**SEL_W).
- SEL_W, 4, width of sel.
- ADDR_W, 4, trace address width; depth DEPTH = 2**ADDR_W.
- WRAP, 0, 0 = stop when full; 1 = circular buffer until stop.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ch_data  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  channel select.
- mode  in  2  0 = every cycle, 1 = on change, 2 = match-trigger then every cycle, 3 = reserved (behaves as 0).
- match_val  in  WIDTH  trigger value for mode 2.
- arm  in  1  single-cycle start pulse.
- stop  in  1  single-cycle stop pulse.
- live_out  out  WIDTH  registered selected channel (the test_out equivalent).
- rd_addr  in  ADDR_W  readout index; 0 = oldest stored sample.
- rd_data  out  WIDTH  trace word; 1-cycle latency.
- count  out  ADDR_W+1  number of valid samples, saturating at DEPTH.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wrapped  out  1  set when a WRAP=1 capture overwrites the oldest entry.

Behaviour:
- Reset values: live_out = 0, rd_data = 0, count = 0, busy = 0, done = 0, wrapped = 0, write pointer = 0, state = IDLE. Trace RAM contents are not reset.
- Channel select: sel >= CHANNELS selects zero. live_out <= selected channel every cycle, independent of capture state.
- Select latch: on an accepted arm, sel, mode and match_val are latched. Later changes to these inputs do not affect the running capture.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE -> (arm & !stop): mode 2 goes to ARMED, other modes go to CAPTURE. Count, pointer and wrapped are cleared, done = 0.
  - ARMED: each cycle the latched channel is compared with the latched match_val. On equality, that same cycle's value is written as sample 0 and the state moves to CAPTURE.
  - CAPTURE, write conditions:
    - modes 0/2/3: one write per cycle.
    - mode 1: a write only when the channel differs from the previously sampled cycle value. The first cycle after arm always writes.
  - WRAP=0: the write that makes count == DEPTH moves to DONE.
  - WRAP=1: writes continue and the pointer wraps modulo DEPTH. The first overwrite sets wrapped; count stays at DEPTH.
  - stop in ARMED or CAPTURE -> DONE; no write occurs in the stop cycle.
  - DONE -> (arm & !stop) restarts exactly as from IDLE. stop in DONE or IDLE has no effect.
  - arm while busy restarts the capture (clear and relatch). If arm and stop are asserted in the same cycle, stop wins.
- Readout:
  - Physical address = rd_addr when !wrapped, else (write pointer + rd_addr) mod DEPTH.
  - rd_data is registered one cycle after rd_addr.
  - rd_addr >= count returns 0.
  - Reads are permitted in any state. A same-cycle read/write of one location returns the old data.
- Reset mid-capture: immediate return to IDLE with all outputs at reset values.
- Widths: the count is ADDR_W+1 bits so that DEPTH is representable. Comparisons are unsigned.

Test Plan:
- Reset, sel=1, ch1 = 0xA5A5_0001 -> live_out = 0xA5A5_0001 one cycle later. sel=7 (CHANNELS=4) -> live_out = 0.
- Mode 0, WRAP=0, ch0 counts 0,1,2…, arm -> DONE after 16 writes. count = 16. rd_addr 0..15 returns 0..15 (offset by the arm latency); busy falls as done rises.
- Mode 1, ch2 holds 5 for 3 cycles, then 9, then 9, then 4, then stop -> count = 3, samples 5, 9, 4.
- Mode 2, match_val = 0x20, ch0 counts from 0 -> ARMED for 32 cycles. Sample 0 = 0x20, last sample = 0x2F, done = 1.
- WRAP=1, mode 0, ch0 counts from 0, stop after 20 writes -> wrapped = 1, count = 16. rd_addr 0 = 4, rd_addr 15 = 19.
- arm and stop asserted together in CAPTURE -> DONE with no write. Assert reset mid-capture -> all outputs 0, state IDLE. A subsequent arm starts from count 0.
